// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_LEN_W  = 24;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN} state_t;

  function automatic int unsigned ceil_words(input int unsigned len,
                                             input int unsigned w = DEF_WORD_W);
    return (len + w - 1) / w;
  endfunction
endpackage

// File: rtl/ccff_serdes.sv
// Word-to-bit serialiser (ibuf) and bit-to-word deserialiser (acc + obuf) for the chain.
module ccff_serdes
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              run,
  input  logic              flush,
  input  logic              ibuf_drop,
  input  logic              in_fire,
  input  logic [WORD_W-1:0] in_data,
  input  logic              out_ready,
  input  logic              ccff_tail,
  output logic              shift,
  output logic              cur_bit,
  output logic              ibuf_empty,
  output logic              ibuf_last,
  output logic              acc_empty,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data
);
  localparam int CW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] ibuf, acc, rem_d, m_d, send_d;
  logic [CW-1:0]     icnt, acnt, rem_c, m_c;
  logic              send, acc_full, obuf_free;

  assign acc_full   = acnt == CW'(WORD_W);
  assign obuf_free  = !out_valid || out_ready;
  assign shift      = run && icnt != '0 && (!acc_full || obuf_free);
  assign cur_bit    = ibuf[WORD_W-1];
  assign ibuf_empty = icnt == '0;
  assign ibuf_last  = icnt == CW'(1);
  assign acc_empty  = acnt == '0;

  // A word completed by this cycle's bit goes straight to obuf when it is free,
  // so the final readback word is presented the cycle after the last shift.
  always_comb begin
    rem_d  = acc;
    rem_c  = acnt;
    send   = 1'b0;
    send_d = acc;
    if (acc_full && obuf_free) begin
      send  = 1'b1;
      rem_d = '0;
      rem_c = '0;
    end
    m_d = rem_d;
    m_c = rem_c;
    if (shift) begin
      for (int i = 0; i < WORD_W; i++)
        if (rem_c == CW'(WORD_W - 1 - i)) m_d[i] = ccff_tail;
      m_c = rem_c + CW'(1);
    end
    if (!send && m_c != '0 && (m_c == CW'(WORD_W) || flush) && obuf_free) begin
      send   = 1'b1;
      send_d = m_d;
      m_d    = '0;
      m_c    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ibuf      <= '0;
      icnt      <= '0;
      acc       <= '0;
      acnt      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_fire) begin
        ibuf <= in_data;
        icnt <= CW'(WORD_W);
      end else if (ibuf_drop) begin
        ibuf <= '0;
        icnt <= '0;
      end else if (shift) begin
        ibuf <= ibuf << 1;
        icnt <= icnt - CW'(1);
      end
      acc  <= m_d;
      acnt <= m_c;
      if (send) begin
        out_data  <= send_d;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_data  <= '0;
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a ccff_head->ccff_tail configuration chain from a word stream and
// returns the displaced chain contents as readback words.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  bits_left
);
  state_t state;
  logic   head_q, run, shift, cur_bit, ibuf_empty, ibuf_last, acc_empty;
  logic   last_shift, in_fire, active;

  assign active     = state != ST_IDLE;
  assign run        = state == ST_LOAD && !cfg_abort && !pReset;
  assign last_shift = shift && bits_left == LEN_W'(1);
  assign in_ready   = run && (ibuf_empty || (shift && ibuf_last)) &&
                      bits_left > LEN_W'(shift);
  assign in_fire    = in_valid && in_ready;

  assign ccff_shift_en = shift;
  assign ccff_head     = shift ? cur_bit : head_q;
  assign busy          = active;

  ccff_serdes #(.WORD_W(WORD_W)) u_serdes (
    .clk       (prog_clk),
    .rst       (pReset),
    .clr       (active && cfg_abort),
    .run       (run),
    .flush     (state == ST_DRAIN || last_shift),
    .ibuf_drop (last_shift),
    .in_fire   (in_fire),
    .in_data   (in_data),
    .out_ready (out_ready),
    .ccff_tail (ccff_tail),
    .shift     (shift),
    .cur_bit   (cur_bit),
    .ibuf_empty(ibuf_empty),
    .ibuf_last (ibuf_last),
    .acc_empty (acc_empty),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state     <= ST_IDLE;
      bits_left <= '0;
      head_q    <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (shift) head_q <= cur_bit;
      case (state)
        ST_IDLE:
          if (cfg_start) begin
            if (cfg_len != '0) begin
              bits_left <= cfg_len;
              state     <= ST_LOAD;
            end else begin
              error <= 1'b1;
            end
          end
        ST_LOAD:
          if (cfg_abort) begin
            error     <= 1'b1;
            bits_left <= '0;
            head_q    <= 1'b0;
            state     <= ST_IDLE;
          end else if (shift) begin
            bits_left <= bits_left - LEN_W'(1);
            if (bits_left == LEN_W'(1)) state <= ST_DRAIN;
          end
        ST_DRAIN:
          if (cfg_abort) begin
            error     <= 1'b1;
            bits_left <= '0;
            head_q    <= 1'b0;
            state     <= ST_IDLE;
          end else if (acc_empty && (!out_valid || out_ready)) begin
            done   <= 1'b1;
            head_q <= 1'b0;
            state  <= ST_IDLE;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
